fp_alu_arbiter: RTL and testbench

Sequencer and arbiter that shares one combinational 32-bit FP ALU (oper 00 add, 01 sub, 10 mul, 11 div) between two requesters.
- Accepts one operation at a time over valid/ready, drives the ALU from registered operands, and captures result plus overflow/underflow/exception.
- Returns the captured result to the granted requester over a valid/ready response channel.
- Sits between the ALU instance and two client blocks, e.g. a vector sequencer and a host register interface.

---
 rtl/fp_alu_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_fp_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fp_alu_arbiter
// Brief   : Two-requester sequencer/arbiter around one shared combinational
//           FP ALU; sticky flag accumulation enabled by FP_ALU_ARB_STICKY_EN.
// Rev     : 1.0
// ============================================================================
module fp_alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_input1,
    input  logic [31:0] req0_input2,
    input  logic [1:0]  req0_oper,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_input1,
    input  logic [31:0] req1_input2,
    input  logic [1:0]  req1_oper,

    output logic [31:0] alu_input1,
    output logic [31:0] alu_input2,
    output logic [1:0]  alu_oper,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_underflow,
    input  logic        alu_exception,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_overflow,
    output logic        resp_underflow,
    output logic        resp_exception,

    input  logic        flag_clr,
    output logic [2:0]  sticky_flags
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last_grant;
    logic        w_grant;
    logic        w_idle;
    logic        w_accept;
    logic        w_capture;

    logic [31:0] r_alu_input1;
    logic [31:0] r_alu_input2;
    logic [1:0]  r_alu_oper;

    logic        r_resp_valid;
    logic        r_resp_id;
    logic [31:0] r_resp_result;
    logic        r_resp_overflow;
    logic        r_resp_underflow;
    logic        r_resp_exception;

    // Requester 0 wins a conflict unless round-robin says it was served last.
    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end else begin
            w_grant = req1_valid;
        end
    end

    assign w_idle     = rst_n && (r_state == ST_IDLE);
    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;
    assign w_capture  = (r_state == ST_EXEC);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
            ST_EXEC:                 w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_grant;
            end
        end
    end

    // Operand registers keep their last value so the ALU inputs stay quiet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_input1 <= 32'd0;
            r_alu_input2 <= 32'd0;
            r_alu_oper   <= 2'd0;
            r_resp_id    <= 1'b0;
        end else if (w_accept) begin
            r_alu_input1 <= w_grant ? req1_input1 : req0_input1;
            r_alu_input2 <= w_grant ? req1_input2 : req0_input2;
            r_alu_oper   <= w_grant ? req1_oper   : req0_oper;
            r_resp_id    <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_valid     <= 1'b0;
            r_resp_result    <= 32'd0;
            r_resp_overflow  <= 1'b0;
            r_resp_underflow <= 1'b0;
            r_resp_exception <= 1'b0;
        end else if (w_capture) begin
            r_resp_valid     <= 1'b1;
            r_resp_result    <= alu_result;
            r_resp_overflow  <= alu_overflow;
            r_resp_underflow <= alu_underflow;
            r_resp_exception <= alu_exception;
        end else if ((r_state == ST_RESP) && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

`ifdef FP_ALU_ARB_STICKY_EN
    logic [2:0] r_sticky;

    // A capture in the same cycle as a clear keeps only that op's flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 3'b000;
        end else if (w_capture) begin
            r_sticky <= (flag_clr ? 3'b000 : r_sticky)
                      | {alu_overflow, alu_underflow, alu_exception};
        end else if (flag_clr) begin
            r_sticky <= 3'b000;
        end
    end

    assign sticky_flags = r_sticky;
`else
    logic w_unused_flag_clr;

    assign w_unused_flag_clr = flag_clr;
    assign sticky_flags      = 3'b000;
`endif

    assign alu_input1     = r_alu_input1;
    assign alu_input2     = r_alu_input2;
    assign alu_oper       = r_alu_oper;
    assign resp_valid     = r_resp_valid;
    assign resp_id        = r_resp_id;
    assign resp_result    = r_resp_result;
    assign resp_overflow  = r_resp_overflow;
    assign resp_underflow = r_resp_underflow;
    assign resp_exception = r_resp_exception;

    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));

    a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
        (req0_ready || req1_ready) |-> (r_state == ST_IDLE));

    a_resp_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready) |=>
            (resp_valid && $stable(resp_result) && $stable(resp_id)));

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_alu_arbiter
// Brief   : Directed, table-driven bench for fp_alu_arbiter with an ALU stub.
// Rev     : 1.0
// ============================================================================
module tb_fp_alu_arbiter;

`ifdef FP_ALU_ARB_STICKY_EN
    localparam bit C_STICKY = 1'b1;
`else
    localparam bit C_STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_input1 = '0, req0_input2 = '0, req1_input1 = '0, req1_input2 = '0;
    logic [1:0]  req0_oper = '0, req1_oper = '0;
    logic        resp_ready = 1'b0;
    logic        flag_clr = 1'b0;

    // round-robin instance outputs
    logic        req0_ready, req1_ready;
    logic [31:0] alu_input1, alu_input2;
    logic [1:0]  alu_oper;
    logic        resp_valid, resp_id;
    logic [31:0] resp_result;
    logic        resp_overflow, resp_underflow, resp_exception;
    logic [2:0]  sticky_flags;

    // fixed-priority instance outputs
    logic        fp_req0_ready, fp_req1_ready;
    logic [31:0] fp_alu_input1, fp_alu_input2;
    logic [1:0]  fp_alu_oper;
    logic        fp_resp_valid, fp_resp_id;
    logic [31:0] fp_resp_result;
    logic        fp_resp_overflow, fp_resp_underflow, fp_resp_exception;
    logic [2:0]  fp_sticky_flags;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        exc;
    } alu_out_t;

    // Stub ALU: known answers for the operand pairs used below.
    function automatic alu_out_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        alu_out_t o;
        o = {a ^ b ^ {30'd0, op}, 3'b000};
        case ({op, a, b})
            {2'b00, 32'h3F800000, 32'h40000000}: o = {32'h40400000, 3'b000};
            {2'b01, 32'h40400000, 32'h3F800000}: o = {32'h40000000, 3'b000};
            {2'b10, 32'h40000000, 32'h40400000}: o = {32'h40C00000, 3'b000};
            {2'b11, 32'h40C00000, 32'h40000000}: o = {32'h40400000, 3'b000};
            {2'b00, 32'h7F800000, 32'h3F800000}: o = {32'h7F800000, 3'b001};
            {2'b11, 32'h3F800000, 32'h00000000}: o = {32'h7F800000, 3'b001};
            {2'b10, 32'h7F000000, 32'h7F000000}: o = {32'h7F800000, 3'b100};
            {2'b10, 32'h00800000, 32'h00800000}: o = {32'h00000000, 3'b010};
            default: ;
        endcase
        return o;
    endfunction

    alu_out_t alu0, alu1;
    always_comb alu0 = alu_model(alu_input1, alu_input2, alu_oper);
    always_comb alu1 = alu_model(fp_alu_input1, fp_alu_input2, fp_alu_oper);

    fp_alu_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_input1(req0_input1),
        .req0_input2(req0_input2), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_input1(req1_input1),
        .req1_input2(req1_input2), .req1_oper(req1_oper),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_oper(alu_oper),
        .alu_result(alu0.res), .alu_overflow(alu0.ovf), .alu_underflow(alu0.unf),
        .alu_exception(alu0.exc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_overflow(resp_overflow),
        .resp_underflow(resp_underflow), .resp_exception(resp_exception),
        .flag_clr(flag_clr), .sticky_flags(sticky_flags)
    );

    fp_alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_input1(req0_input1),
        .req0_input2(req0_input2), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_input1(req1_input1),
        .req1_input2(req1_input2), .req1_oper(req1_oper),
        .alu_input1(fp_alu_input1), .alu_input2(fp_alu_input2), .alu_oper(fp_alu_oper),
        .alu_result(alu1.res), .alu_overflow(alu1.ovf), .alu_underflow(alu1.unf),
        .alu_exception(alu1.exc),
        .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
        .resp_result(fp_resp_result), .resp_overflow(fp_resp_overflow),
        .resp_underflow(fp_resp_underflow), .resp_exception(fp_resp_exception),
        .flag_clr(flag_clr), .sticky_flags(fp_sticky_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic [2:0]  flags;   // {ovf, unf, exc}
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op from IDLE with resp_ready high; optionally pulse flag_clr in EXEC.
    task automatic run_vec(input vec_t v, input logic clr_in_exec);
        resp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_input1 = v.a; req1_input2 = v.b; req1_oper = v.op;
        end else begin
            req0_valid = 1'b1; req0_input1 = v.a; req0_input2 = v.b; req0_oper = v.op;
        end
        #1;
        check("ready", 32'(v.id ? req1_ready : req0_ready), 32'd1);
        check("other_ready", 32'(v.id ? req0_ready : req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_input1 = 32'hDEADBEEF; req0_input2 = 32'h01234567; req0_oper = ~v.op;
        req1_input1 = 32'hCAFEF00D; req1_input2 = 32'h89ABCDEF; req1_oper = ~v.op;
        flag_clr = clr_in_exec;
        check("alu_input1", alu_input1, v.a);
        check("alu_input2", alu_input2, v.b);
        check("alu_oper", 32'(alu_oper), 32'(v.op));
        check("resp_valid_exec", 32'(resp_valid), 32'd0);
        step();
        flag_clr = 1'b0;
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_result", resp_result, v.res);
        check("resp_id", 32'(resp_id), 32'(v.id));
        check("resp_flags", 32'({resp_overflow, resp_underflow, resp_exception}), 32'(v.flags));
        step();
        check("resp_valid_done", 32'(resp_valid), 32'd0);
        check("alu_hold", alu_input1, v.a);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 3'b000};
        vecs[1] = '{1'b1, 32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 3'b000};
        vecs[2] = '{1'b0, 32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 3'b000};
        vecs[3] = '{1'b1, 32'h40C00000, 32'h40000000, 2'b11, 32'h40400000, 3'b000};
        vecs[4] = '{1'b1, 32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 3'b001};
        vecs[5] = '{1'b0, 32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000, 3'b001};
        vecs[6] = '{1'b1, 32'h7F000000, 32'h7F000000, 2'b10, 32'h7F800000, 3'b100};
        vecs[7] = '{1'b0, 32'h00800000, 32'h00800000, 2'b10, 32'h00000000, 3'b010};

        // Reset with both requesters asserting: everything must read 0.
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_input1 = 32'h11111111; req1_input1 = 32'h22222222; resp_ready = 1'b1;
        step(); step();
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_alu_input1", alu_input1, 32'd0);
        check("rst_alu_oper", 32'(alu_oper), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], 1'b0);
        end
        check("sticky_accum", 32'(sticky_flags), C_STICKY ? 32'h7 : 32'h0);

        flag_clr = 1'b1; step(); flag_clr = 1'b0;
        check("sticky_clr", 32'(sticky_flags), 32'h0);
        run_vec(vecs[6], 1'b0);
        run_vec(vecs[0], 1'b0);
        check("sticky_ovf_only", 32'(sticky_flags), C_STICKY ? 32'h4 : 32'h0);
        run_vec(vecs[4], 1'b1);
        check("sticky_clr_vs_capture", 32'(sticky_flags), C_STICKY ? 32'h1 : 32'h0);

        // Both requesters held valid: round-robin alternates, fixed priority keeps id 0.
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_input1 = 32'h40000000; req0_input2 = 32'h40400000; req0_oper = 2'b10;
        req1_valid = 1'b1; req1_input1 = 32'h40C00000; req1_input2 = 32'h40000000; req1_oper = 2'b11;
        step();
        rst_n = 1'b1;
        begin
            int got = 0;
            int last_c = 0;
            for (int c = 0; c < 20 && got < 4; c++) begin
                step();
                if (resp_valid) begin
                    check("rr_id", 32'(resp_id), 32'(got % 2));
                    check("rr_result", resp_result, (got % 2) ? 32'h40400000 : 32'h40C00000);
                    check("fp_valid", 32'(fp_resp_valid), 32'd1);
                    check("fp_id", 32'(fp_resp_id), 32'd0);
                    check("fp_result", fp_resp_result, 32'h40C00000);
                    if (got > 0) check("rr_gap", 32'(c - last_c), 32'd3);
                    last_c = c;
                    got++;
                end
            end
            check("rr_count", 32'(got), 32'd4);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Backpressure: response held, req1 locked out until the cycle after resp_ready.
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_input1 = 32'h3F800000; req0_input2 = 32'h40000000; req0_oper = 2'b00;
        #1;
        check("bp_req0_ready", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_input1 = 32'h40C00000; req1_input2 = 32'h40000000; req1_oper = 2'b11;
        #1;
        check("bp_req1_exec", 32'(req1_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_result", resp_result, 32'h40400000);
            check("bp_id", 32'(resp_id), 32'd0);
            check("bp_req1_blocked", 32'(req1_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_req1_resp_hs", 32'(req1_ready), 32'd0);
        step();
        check("bp_valid_drop", 32'(resp_valid), 32'd0);
        check("bp_req1_accept", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        check("bp_alu_input1", alu_input1, 32'h40C00000);
        step();
        check("bp_resp2_valid", 32'(resp_valid), 32'd1);
        check("bp_resp2_id", 32'(resp_id), 32'd1);
        check("bp_resp2_result", resp_result, 32'h40400000);
        step();

        // Reset during EXEC discards the op.
        req0_valid = 1'b1; req0_input1 = 32'h7F000000; req0_input2 = 32'h7F000000; req0_oper = 2'b10;
        #1;
        check("mid_accept", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_resp_ovf", 32'(resp_overflow), 32'd0);
        check("mid_alu_input1", alu_input1, 32'd0);
        check("mid_sticky", 32'(sticky_flags), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_resp", 32'(resp_valid), 32'd0);
        end
        run_vec(vecs[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
